pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port: pc_src  input  1  taken-branch/jump redirect strobe, sampled every cycle.
REQ-005 Port: pc_target  input  32  redirect address, valid when pc_src=1.
REQ-006 Port: stall  input  1  blocks issue of new fetch requests.
REQ-007 Port: imem_req  output  1  fetch request valid.
REQ-008 Port: imem_addr  output  32  fetch address, stable while imem_req=1 and no redirect.
REQ-009 Port: imem_ready  input  1  memory accepts request when imem_req & imem_ready.
REQ-010 Port: imem_rvalid  input  1  read data valid, exactly one per accepted request.
REQ-011 Port: imem_rdata  input  32  instruction word.
REQ-012 Port: instr_valid  output  1  instruction available to decode.
REQ-013 Port: instr  output  32  registered instruction word.
REQ-014 Port: instr_pc  output  32  address of instr.
REQ-015 Port: instr_ready  input  1  decode consumes instr when instr_valid & instr_ready.
REQ-016 Port: misalign_err  output  1  one-cycle pulse, misaligned redirect rejected.

Function
REQ-017 FSM states: S_REQ (issue), S_WAIT (one request outstanding), S_OUT (holding instr); at most one outstanding request.
REQ-018 S_REQ: imem_req = ~stall; on imem_req & imem_ready -> S_WAIT, capture imem_addr into pending_pc.
REQ-019 S_WAIT: on imem_rvalid with drop=0 -> load instr=imem_rdata, instr_pc=pending_pc, instr_valid=1 next cycle, -> S_OUT.
REQ-020 S_WAIT: on imem_rvalid with drop=1 -> discard data, clear drop, -> S_REQ; instr_valid stays 0.
REQ-021 S_OUT: on instr_ready -> instr_valid=0, imem_addr=instr_pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), -> S_REQ.
REQ-022 Minimum latency: request accepted cycle N, rvalid N+1, instr_valid N+2; back-to-back throughput one instruction per 3 cycles.
REQ-023 Redirect (pc_src=1) in S_REQ: next-cycle imem_addr=pc_target; if request accepted same cycle, set drop, go S_WAIT.
REQ-024 Redirect in S_WAIT: set drop; next fetch address=pc_target; if imem_rvalid same cycle, data discarded, -> S_REQ.
REQ-025 Redirect in S_OUT: instr_valid=0 next cycle regardless of instr_ready, imem_addr=pc_target, -> S_REQ.
REQ-026 Repeated redirects while drop pending: latest pc_target wins; drop remains single-bit (one response discarded).
REQ-027 Redirect has priority over stall and over sequential increment; stall never blocks redirect capture.
REQ-028 stall affects only request issue; outstanding response and instr_valid/instr_ready handshake proceed.
REQ-029 instr, instr_pc held stable while instr_valid=1 and instr_ready=0.

Reset
REQ-030 rst_n=0 at rising edge: state=S_REQ, imem_addr=RESET_PC, drop=0, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, misalign_err=0; imem_req=0 during reset cycle.
REQ-031 Reset mid-operation: outstanding response arriving after reset is ignored (drop=1 set on release if reset occurred in S_WAIT).

Configuration
REQ-032 Macro MISALIGN_TRAP_EN defined: redirect with pc_target[1:0]!=0 is ignored, misalign_err pulses one cycle, sequential fetch continues.
REQ-033 MISALIGN_TRAP_EN undefined: pc_target[1:0] forced to 2'b00 on redirect; misalign_err tied 0.

Verification
REQ-034 Reset release, imem_ready=1, rvalid one cycle later, instr_ready=1 -> addresses 0x0, 0x4, 0x8 fetched, instr_valid every 3rd cycle.
REQ-035 pc_src=1, pc_target=0x100 while in S_WAIT for 0x8 -> 0x8 data discarded, next imem_addr=0x100, instr_pc=0x100.
REQ-036 instr_ready=0 for 5 cycles in S_OUT -> instr/instr_pc stable, imem_req=0, no new request.
REQ-037 stall=1 for 4 cycles in S_REQ -> imem_req=0; redirect to 0x200 during stall -> first request after stall at 0x200.
REQ-038 pc_target=0x102 with MISALIGN_TRAP_EN -> misalign_err=1 one cycle, fetch continues at instr_pc+4; without macro -> fetch at 0x100.
REQ-039 instr_pc=0xFFFF_FFFC consumed -> next imem_addr=0x0000_0000.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, redirect with response drop, registered instr output.
// Optional MISALIGN_TRAP_EN: reject misaligned redirects and pulse misalign_err instead of truncating.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        misalign_err
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pending_pc_q, pending_pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            instr_valid_q, instr_valid_d;
  logic            drop_q, drop_d;
  logic            misalign_q, misalign_d;

  logic            redir_c;
  logic            misalign_c;
  logic [XLEN-1:0] redir_pc_c;
  logic            accept_c;

  // Redirect qualification: trap or word-align the target
`ifdef MISALIGN_TRAP_EN
  assign redir_c    = pc_src & (pc_target[1:0] == 2'b00);
  assign misalign_c = pc_src & (pc_target[1:0] != 2'b00);
`else
  assign redir_c    = pc_src;
  assign misalign_c = 1'b0;
`endif
  assign redir_pc_c = pc_target & ~XLEN'(3);

  assign imem_req  = rst_n & (state_q == S_REQ) & ~stall;
  assign accept_c  = imem_req & imem_ready;

  assign imem_addr    = fetch_pc_q;
  assign instr_valid  = instr_valid_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign misalign_err = misalign_q;

  // Next-state and datapath updates
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    pending_pc_d  = pending_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    drop_d        = drop_q;
    misalign_d    = misalign_c;

    case (state_q)
      S_REQ: begin
        // A stale response (after reset) may land here; it retires the drop
        drop_d = drop_q & ~imem_rvalid;
        if (redir_c) fetch_pc_d = redir_pc_c;
        if (accept_c) begin
          pending_pc_d = fetch_pc_q;
          state_d      = S_WAIT;
          if (redir_c) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (redir_c) fetch_pc_d = redir_pc_c;
        if (imem_rvalid) begin
          if (drop_q || redir_c) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d       = imem_rdata;
            instr_pc_d    = pending_pc_q;
            instr_valid_d = 1'b1;
            state_d       = S_OUT;
          end
        end else if (redir_c) begin
          drop_d = 1'b1;
        end
      end
      S_OUT: begin
        if (redir_c) begin
          instr_valid_d = 1'b0;
          fetch_pc_d    = redir_pc_c;
          state_d       = S_REQ;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          fetch_pc_d    = instr_pc_q + PC_STEP;
          state_d       = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // State register; reset in S_WAIT arms a drop for the orphaned response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      fetch_pc_q    <= RESET_PC;
      pending_pc_q  <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
      drop_q        <= (state_q == S_WAIT) | (drop_q & ~imem_rvalid);
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      pending_pc_q  <= pending_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      drop_q        <= drop_d;
      misalign_q    <= misalign_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: queued memory responder plus instruction scoreboard.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, pc_src, stall, imem_req, imem_ready, imem_rvalid;
  logic        instr_valid, instr_ready, misalign_err;
  logic [31:0] pc_target, imem_addr, imem_rdata, instr, instr_pc;

  typedef struct packed { logic [31:0] pc; logic [31:0] word; } exp_t;
  exp_t        sb_q[$];
  logic [31:0] resp_q[$];
  logic        hold_resp;
  logic        redir_eff;
  int          checks = 0;
  int          fails  = 0;

  always #10 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .pc_target(pc_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready), .misalign_err(misalign_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  function automatic exp_t mk(input logic [31:0] a);
    exp_t e;
    e.pc = a;
    e.word = mem_word(a);
    return e;
  endfunction

`ifdef MISALIGN_TRAP_EN
  always_comb redir_eff = pc_src && (pc_target[1:0] == 2'b00);
`else
  always_comb redir_eff = pc_src;
`endif

  // Memory: in-order responses, one cycle after acceptance unless held back
  initial begin
    logic        acc;
    logic [31:0] a;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk); #3;
      acc = imem_req & imem_ready;
      a   = imem_addr;
      @(posedge clk); #1;
      if (acc) resp_q.push_back(a);
      if (!hold_resp && resp_q.size() > 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(resp_q.pop_front());
      end else begin
        imem_rvalid = 1'b0;
      end
    end
  end

  // Scoreboard: every consumed instruction must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #4;
      if (rst_n && instr_valid && instr_ready && !redir_eff) begin
        checks++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got pc=%h instr=%h, required nothing pending", instr_pc, instr);
        end else begin
          e = sb_q.pop_front();
          if (instr_pc !== e.pc || instr !== e.word) begin
            fails++;
            $display("FAIL sb_instr: got pc=%h instr=%h, required pc=%h instr=%h", instr_pc, instr, e.pc, e.word);
          end
        end
      end
    end
  end

  task automatic next_cyc();
    @(negedge clk); #1;
  endtask

  task automatic wait_valid(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      next_cyc(); #1;
      if (instr_valid === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin fails++; $display("FAIL %s_timeout: got no instr_valid, required one within 12 cycles", name); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc_src = 1'b0; pc_target = 32'h0; stall = 1'b0;
    imem_ready = 1'b1; instr_ready = 1'b1; hold_resp = 1'b0;
    repeat (3) next_cyc();
    #1;
    checks += 5;
    if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b required 0", imem_req); end
    if (imem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr: got %h required 0", imem_addr); end
    if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b required 0", instr_valid); end
    if (instr !== 32'h0000_0013) begin fails++; $display("FAIL rst_instr: got %h required 00000013", instr); end
    if (instr_pc !== 32'h0 || misalign_err !== 1'b0) begin
      fails++; $display("FAIL rst_pc_err: got pc=%h err=%b required 0/0", instr_pc, misalign_err);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] ea;
    sb_q.push_back(mk(32'h0));
    sb_q.push_back(mk(32'h4));
    for (int i = 0; i < 7; i++) begin
      next_cyc();
      if (i == 0) rst_n = 1'b1;
      #1;
      ea = 32'(i / 3) * 32'd4;
      checks += 2;
      if (imem_req !== (i % 3 == 0)) begin fails++; $display("FAIL seq_req[%0d]: got %b required %b", i, imem_req, (i % 3 == 0)); end
      if (instr_valid !== (i % 3 == 2)) begin fails++; $display("FAIL seq_valid[%0d]: got %b required %b", i, instr_valid, (i % 3 == 2)); end
      if (i % 3 == 0) begin
        checks++;
        if (imem_addr !== ea) begin fails++; $display("FAIL seq_addr[%0d]: got %h required %h", i, imem_addr, ea); end
      end
      if (i % 3 == 2) begin
        checks++;
        if (instr_pc !== ea) begin fails++; $display("FAIL seq_pc[%0d]: got %h required %h", i, instr_pc, ea); end
      end
    end
  endtask

  task automatic test_redirect_wait();
    next_cyc(); pc_src = 1'b1; pc_target = 32'h100; #1;
    checks++;
    if (instr_valid !== 1'b0) begin fails++; $display("FAIL rw_valid: got %b required 0", instr_valid); end
    next_cyc(); pc_src = 1'b0; #1;
    checks += 2;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin fails++; $display("FAIL rw_addr: got req=%b addr=%h required 1/00000100", imem_req, imem_addr); end
    if (instr_valid !== 1'b0) begin fails++; $display("FAIL rw_discard: got valid=%b required 0", instr_valid); end
    sb_q.push_back(mk(32'h100));
    wait_valid("rw");
  endtask

  task automatic test_drop_repeat();
    next_cyc(); hold_resp = 1'b1; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin fails++; $display("FAIL dr_addr: got req=%b addr=%h required 1/00000104", imem_req, imem_addr); end
    next_cyc(); pc_src = 1'b1; pc_target = 32'h300;
    next_cyc(); pc_target = 32'h400; hold_resp = 1'b0;
    next_cyc(); pc_src = 1'b0; instr_ready = 1'b0; #1;
    checks++;
    if (instr_valid !== 1'b0) begin fails++; $display("FAIL dr_stale: got valid=%b required 0", instr_valid); end
    next_cyc(); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h400 || instr_valid !== 1'b0) begin
      fails++; $display("FAIL dr_latest: got req=%b addr=%h valid=%b required 1/00000400/0", imem_req, imem_addr, instr_valid);
    end
    sb_q.push_back(mk(32'h400));
    wait_valid("dr");
  endtask

  task automatic test_out_hold();
    for (int i = 0; i < 5; i++) begin
      next_cyc(); #1;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h400 || instr !== mem_word(32'h400) || imem_req !== 1'b0) begin
        fails++; $display("FAIL hold[%0d]: got valid=%b pc=%h instr=%h req=%b required 1/00000400/%h/0", i, instr_valid, instr_pc, instr, imem_req, mem_word(32'h400));
      end
    end
    next_cyc(); instr_ready = 1'b1;
    next_cyc(); instr_ready = 1'b0; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h404) begin fails++; $display("FAIL hold_next: got req=%b addr=%h required 1/00000404", imem_req, imem_addr); end
    wait_valid("ho");
  endtask

  task automatic test_redirect_out();
    pc_src = 1'b1; pc_target = 32'h500; stall = 1'b1; instr_ready = 1'b1;
    next_cyc(); pc_src = 1'b0; #1;
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h500 || imem_req !== 1'b0) begin
      fails++; $display("FAIL ro: got valid=%b addr=%h req=%b required 0/00000500/0", instr_valid, imem_addr, imem_req);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      pc_src = (i == 1); pc_target = 32'h200;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin fails++; $display("FAIL stall_req[%0d]: got %b required 0", i, imem_req); end
    end
    next_cyc(); pc_src = 1'b0; stall = 1'b0; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin fails++; $display("FAIL stall_redir: got req=%b addr=%h required 1/00000200", imem_req, imem_addr); end
    sb_q.push_back(mk(32'h200));
    wait_valid("st");
    stall = 1'b1;
    next_cyc(); #1;
    checks++;
    if (imem_addr !== 32'h204 || imem_req !== 1'b0) begin fails++; $display("FAIL stall_seq: got addr=%h req=%b required 00000204/0", imem_addr, imem_req); end
  endtask

  task automatic test_misalign();
    logic [31:0] ea;
    logic        eerr;
`ifdef MISALIGN_TRAP_EN
    ea = 32'h204; eerr = 1'b1;
`else
    ea = 32'h100; eerr = 1'b0;
`endif
    next_cyc(); pc_src = 1'b1; pc_target = 32'h102;
    next_cyc(); pc_src = 1'b0; #1;
    checks += 2;
    if (misalign_err !== eerr) begin fails++; $display("FAIL mis_err: got %b required %b", misalign_err, eerr); end
    if (imem_addr !== ea) begin fails++; $display("FAIL mis_addr: got %h required %h", imem_addr, ea); end
    next_cyc(); stall = 1'b0; #1;
    checks++;
    if (misalign_err !== 1'b0) begin fails++; $display("FAIL mis_pulse: got %b required 0", misalign_err); end
    sb_q.push_back(mk(ea));
    wait_valid("mis");
    stall = 1'b1;
  endtask

  task automatic test_wrap();
    next_cyc(); pc_src = 1'b1; pc_target = 32'hFFFF_FFFC;
    next_cyc(); pc_src = 1'b0; stall = 1'b0; #1;
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_top: got %h required fffffffc", imem_addr); end
    sb_q.push_back(mk(32'hFFFF_FFFC));
    wait_valid("wr");
    stall = 1'b1;
    next_cyc(); #1;
    checks++;
    if (imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_zero: got %h required 00000000", imem_addr); end
  endtask

  task automatic test_reset_in_wait();
    next_cyc(); pc_src = 1'b1; pc_target = 32'h40;
    next_cyc(); pc_src = 1'b0; stall = 1'b0; hold_resp = 1'b1; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin fails++; $display("FAIL rw_req: got req=%b addr=%h required 1/00000040", imem_req, imem_addr); end
    next_cyc(); rst_n = 1'b0; stall = 1'b1;
    next_cyc(); #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr !== 32'h0000_0013 || instr_valid !== 1'b0) begin
      fails++; $display("FAIL midrst: got req=%b addr=%h instr=%h valid=%b required 0/00000000/00000013/0", imem_req, imem_addr, instr, instr_valid);
    end
    rst_n = 1'b1; stall = 1'b0;
    next_cyc(); hold_resp = 1'b0;
    next_cyc(); #1;
    checks++;
    if (instr_valid !== 1'b0) begin fails++; $display("FAIL midrst_stale: got valid=%b required 0", instr_valid); end
    sb_q.push_back(mk(32'h0));
    wait_valid("mr");
    stall = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect_wait();
    test_drop_repeat();
    test_out_hold();
    test_redirect_out();
    test_stall();
    test_misalign();
    test_wrap();
    test_reset_in_wait();
    repeat (4) next_cyc();
    checks++;
    if (sb_q.size() != 0) begin fails++; $display("FAIL sb_leftover: got %0d pending required 0", sb_q.size()); end
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
